// File: rtl/gpio_serial_rx_if.sv
// Signal bundle between the Raspberry Pi GPIO serial link and the receiver.
// The master side is the sender (pins plus observer of the results); the
// slave side is the receiver that samples the pins and reports bytes.
interface gpio_serial_rx_if;
    logic       in_sclk;
    logic       in_sdat;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic [7:0] frame_cnt;

    modport master (
        output in_sclk,
        output in_sdat,
        input  data,
        input  valid,
        input  busy,
        input  frame_err,
        input  frame_cnt
    );

    modport slave (
        input  in_sclk,
        input  in_sdat,
        output data,
        output valid,
        output busy,
        output frame_err,
        output frame_cnt
    );
endinterface

// File: rtl/gpio_serial_rx.sv
// Receiver for an 8-bit MSB-first serial frame strobed in by GPIO pins that
// are asynchronous to clk. Both pins are synchronized, the strobe's rising
// edge samples the data bit, and a completed byte is presented on data with
// a one-cycle valid pulse. A stalled partial frame is dropped after TIMEOUT
// clk cycles without a strobe edge and reported with frame_err.
module gpio_serial_rx #(
    parameter int TIMEOUT = 50000
) (
    input logic            clk,
    input logic            rst,
    gpio_serial_rx_if.slave bus
);
    localparam int SYNC_STAGES = 2;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic          sclk_sync_reg [0:SYNC_STAGES-1];
    logic          sdat_sync_reg [0:SYNC_STAGES-1];
    logic          sclk_prev_reg;

    state_t        state_reg;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt_reg;
    logic [TW-1:0] tcnt_reg;
    logic [7:0]    data_reg;
    logic          valid_reg;
    logic          frame_err_reg;
    logic [7:0]    frame_cnt_reg;

    logic          edge_event;
    logic          sdat_bit;
    logic [7:0]    shifted;

    // Synchronizer chains; the strobe chain resets high so a strobe already
    // high when reset releases does not look like a rising edge.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            // First stage samples the raw pins.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sclk_sync_reg[gi] <= 1'b1;
                    sdat_sync_reg[gi] <= 1'b0;
                end else begin
                    sclk_sync_reg[gi] <= bus.in_sclk;
                    sdat_sync_reg[gi] <= bus.in_sdat;
                end
            end
        end else begin : g_chain
            // Later stages only follow the previous stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sclk_sync_reg[gi] <= 1'b1;
                    sdat_sync_reg[gi] <= 1'b0;
                end else begin
                    sclk_sync_reg[gi] <= sclk_sync_reg[gi-1];
                    sdat_sync_reg[gi] <= sdat_sync_reg[gi-1];
                end
            end
        end
    end

    // Remember the previous synchronized strobe for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev_reg <= 1'b1;
        end else begin
            sclk_prev_reg <= sclk_sync_reg[SYNC_STAGES-1];
        end
    end

    assign edge_event = sclk_sync_reg[SYNC_STAGES-1] & ~sclk_prev_reg;
    assign sdat_bit   = sdat_sync_reg[SYNC_STAGES-1];
    assign shifted    = {shift_reg[6:0], sdat_bit};

    // Frame FSM: collects bits, publishes complete bytes, aborts on timeout.
    // An edge arriving in the same cycle as the timeout limit takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= 8'h00;
            bit_cnt_reg   <= 3'd0;
            tcnt_reg      <= '0;
            data_reg      <= 8'h00;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            frame_cnt_reg <= 8'h00;
        end else begin
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tcnt_reg <= '0;
                    if (edge_event) begin
                        state_reg   <= SHIFT;
                        shift_reg   <= {7'd0, sdat_bit};
                        bit_cnt_reg <= 3'd1;
                    end
                end
                SHIFT: begin
                    if (edge_event) begin
                        tcnt_reg <= '0;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg     <= IDLE;
                            data_reg      <= shifted;
                            valid_reg     <= 1'b1;
                            frame_cnt_reg <= frame_cnt_reg + 8'd1;
                            shift_reg     <= 8'h00;
                            bit_cnt_reg   <= 3'd0;
                        end else begin
                            shift_reg   <= shifted;
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end else if (tcnt_reg == T_LAST) begin
                        state_reg     <= IDLE;
                        frame_err_reg <= 1'b1;
                        shift_reg     <= 8'h00;
                        bit_cnt_reg   <= 3'd0;
                        tcnt_reg      <= '0;
                    end else begin
                        tcnt_reg <= tcnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.data      = data_reg;
    assign bus.valid     = valid_reg;
    assign bus.busy      = (state_reg == SHIFT);
    assign bus.frame_err = frame_err_reg;
    assign bus.frame_cnt = frame_cnt_reg;
endmodule

// File: tb/tb_gpio_serial_rx.sv
// Directed bench for gpio_serial_rx: bytes are clocked in over the strobe,
// expected {byte, frame count} pairs are queued when sent and compared when
// the receiver reports them.
module tb_gpio_serial_rx;
    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gpio_serial_rx_if bus ();

    gpio_serial_rx #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Receiver observations, written only by the monitor.
    logic [7:0] obs_data [0:1023];
    logic [7:0] obs_cnt  [0:1023];
    logic       obs_busy [0:1023];
    int obs_wr   = 0;
    int ferr_cnt = 0;
    int overlap_cnt = 0;

    // Monitor: log each valid pulse, count frame_err pulses and overlaps.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            obs_data[obs_wr] <= bus.data;
            obs_cnt[obs_wr]  <= bus.frame_cnt;
            obs_busy[obs_wr] <= bus.busy;
            obs_wr <= obs_wr + 1;
        end
        if (bus.frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (bus.valid === 1'b1 && bus.frame_err === 1'b1) overlap_cnt <= overlap_cnt + 1;
    end

    logic [15:0] exp_q [$];
    logic [7:0]  exp_cnt = 8'h00;
    int          obs_rd = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    task automatic send_bit(input logic b, input int half);
        bus.in_sclk = 1'b0;
        bus.in_sdat = b;
        wait_cycles(half);
        bus.in_sclk = 1'b1;
        wait_cycles(half);
    endtask

    task automatic send_byte(input logic [7:0] b, input int half);
        logic [7:0] v;
        v = b;
        for (int i = 7; i >= 0; i--) send_bit(v[i], half);
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back({v, exp_cnt});
    endtask

    task automatic drain(input string tag);
        logic [15:0] e;
        int n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = 0;
            while (obs_rd >= obs_wr && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (obs_rd >= obs_wr) begin
                chk({tag, "_valid_timeout"}, 32'(obs_wr), 32'(obs_rd + 1));
            end else begin
                chk({tag, "_data"}, 32'(obs_data[obs_rd]), 32'(e[15:8]));
                chk({tag, "_frame_cnt"}, 32'(obs_cnt[obs_rd]), 32'(e[7:0]));
                chk({tag, "_busy_at_valid"}, 32'(obs_busy[obs_rd]), 32'd0);
                obs_rd++;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        wait_cycles(cycles);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 8'h00;
    endtask

    initial begin
        int ferr_before;
        int wr_before;
        bus.in_sclk = 1'b1;
        bus.in_sdat = 1'b0;

        // Reset with strobe held high; release must not create an edge.
        wait_cycles(5);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_data", 32'(bus.data), 32'h00);
        chk("reset_valid", 32'(bus.valid), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
        chk("reset_frame_cnt", 32'(bus.frame_cnt), 32'h00);
        wait_cycles(10);
        @(negedge clk);
        chk("no_spurious_busy", 32'(bus.busy), 32'd0);

        send_byte(8'h01, 10);
        drain("byte01");

        send_byte(8'hA5, 10);
        drain("byteA5");
        wait_cycles(5);
        @(negedge clk);
        chk("a5_busy_after", 32'(bus.busy), 32'd0);
        chk("a5_data_hold", 32'(bus.data), 32'hA5);

        // Back-to-back frames.
        send_byte(8'h3C, 10);
        send_byte(8'hFF, 10);
        drain("b2b");
        chk("b2b_data_end", 32'(bus.data), 32'hFF);
        chk("b2b_no_frame_err", 32'(ferr_cnt), 32'd0);

        // Partial frame followed by a stalled strobe.
        ferr_before = ferr_cnt;
        wr_before = obs_wr;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 10);
        wait_cycles(TIMEOUT - 15);
        @(negedge clk);
        chk("timeout_not_early", 32'(ferr_cnt), 32'(ferr_before));
        chk("timeout_busy_during", 32'(bus.busy), 32'd1);
        wait_cycles(30);
        @(negedge clk);
        chk("timeout_frame_err", 32'(ferr_cnt), 32'(ferr_before + 1));
        chk("timeout_busy_after", 32'(bus.busy), 32'd0);
        chk("timeout_data_kept", 32'(bus.data), 32'hFF);
        chk("timeout_cnt_kept", 32'(bus.frame_cnt), 32'(exp_cnt));
        chk("timeout_no_valid", 32'(obs_wr), 32'(wr_before));

        send_byte(8'h81, 10);
        drain("byte81");

        // Reset in the middle of a frame.
        ferr_before = ferr_cnt;
        wr_before = obs_wr;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 10);
        do_reset(3);
        wait_cycles(5);
        @(negedge clk);
        chk("midrst_no_valid", 32'(obs_wr), 32'(wr_before));
        chk("midrst_no_frame_err", 32'(ferr_cnt), 32'(ferr_before));
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_data_cleared", 32'(bus.data), 32'h00);
        send_byte(8'h7E, 10);
        drain("byte7E");

        // 256 frames from a fresh reset: count wraps back to zero.
        do_reset(3);
        wait_cycles(3);
        for (int f = 0; f < 256; f++) begin
            send_byte(8'(f * 37 + 5), 4);
            drain("wrap");
        end
        chk("wrap_frame_cnt", 32'(bus.frame_cnt), 32'h00);
        chk("never_valid_and_err", 32'(overlap_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gpio_serial_rx.md
GPIO_SERIAL_RX -- requirements
Module: gpio_serial_rx

Interface
REQ-001 Parameter: TIMEOUT, 50000, clk cycles allowed between in_sclk rising edges inside a frame before the frame is aborted (1 ms at 50 MHz).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge; single clock domain.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_sclk  input  1  serial strobe from Raspberry Pi GPIO20, asynchronous to clk.
REQ-005 Port: in_sdat  input  1  serial data from Raspberry Pi GPIO21, asynchronous to clk.
REQ-006 Port: data  output  8  last complete received byte; drives the downstream seg/LED stage in place of the free-running count.
REQ-007 Port: valid  output  1  one-cycle pulse when data updates.
REQ-008 Port: busy  output  1  high while a frame is partially received.
REQ-009 Port: frame_err  output  1  one-cycle pulse when a partial frame is aborted on timeout.
REQ-010 Port: frame_cnt  output  8  count of good frames received, wraps 255 -> 0.

Function
REQ-011 in_sclk and in_sdat SHALL each pass through a 2-flop synchronizer before any use; no logic SHALL consume the raw pins.
REQ-012 An edge event SHALL be: synchronized sclk = 1 and its registered previous value = 0 (rising edge only); falling edges ignored.
REQ-013 On an edge event, the synchronized in_sdat value in that same cycle SHALL be the sampled bit.
REQ-014 Frames are 8 bits, MSB first; bits shift into an internal 8-bit shift register from the LSB end.
REQ-015 States: IDLE, SHIFT. IDLE -> SHIFT on the first edge event (bit count becomes 1); SHIFT -> IDLE on the 8th edge event, on timeout, or on rst.
REQ-016 On the 8th edge event: data <= completed byte, valid = 1 for exactly one cycle, frame_cnt += 1 (mod 256), all at the next clk edge.
REQ-017 Latency: valid SHALL assert on the 3rd rising clk edge after the 8th in_sclk rising edge is first captured by the synchronizer's first flop.
REQ-018 busy SHALL equal (state == SHIFT); busy is low in the cycle valid is high.
REQ-019 A timeout counter SHALL run only in SHIFT, clear on every edge event, and be cleared on entry to SHIFT.
REQ-020 When the counter reaches TIMEOUT-1 without an edge: frame_err = 1 for one cycle, partial bits discarded, state -> IDLE, data and frame_cnt unchanged.
REQ-021 Edge event and timeout in the same cycle: the edge wins; no frame_err.
REQ-022 data SHALL hold its value between valid pulses; valid and frame_err SHALL never be high in the same cycle.
REQ-023 Back-to-back frames SHALL be accepted with no idle gap: the edge after the 8th starts a new frame.

Reset
REQ-024 While rst = 1 at a clk edge: state = IDLE, data = 8'h00, valid = 0, busy = 0, frame_err = 0, frame_cnt = 8'h00, shift register, bit count and timeout counter = 0.
REQ-025 sclk synchronizer flops and the previous-value flop SHALL reset to 1, so in_sclk held high through reset release creates no edge event; sdat synchronizer flops reset to 0.
REQ-026 rst asserted mid-frame SHALL discard the partial frame with no valid or frame_err pulse.

Verification
REQ-027 Send 8'hA5 MSB first, sclk period 20 clk -> one valid pulse, data = 8'hA5, frame_cnt = 1, busy low after.
REQ-028 Send 8'h3C then 8'hFF back-to-back -> two valid pulses, data ends 8'hFF, frame_cnt = 2, no frame_err.
REQ-029 Send 5 bits then hold sclk low for TIMEOUT (set TIMEOUT = 100) -> frame_err pulse on cycle 100 after last edge, data unchanged, next full 8'h81 received correctly.
REQ-030 Hold in_sclk = 1 during and after reset, then send 8'h01 -> no spurious bit; data = 8'h01.
REQ-031 Assert rst after 4 bits, release, send 8'h7E -> no pulses during reset, data = 8'h7E, frame_cnt = 1.
REQ-032 Send 256 frames -> frame_cnt wraps to 8'h00 on the 256th valid.
